// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 multiplier: shift-add significand product, normalise, round, flags.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_mul_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int BIAS   = (1 << (EXP_W - 1)) - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     in1,
    input  logic [EXP_W+FRAC_W:0]     in2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out,
    output logic [3:0]                flags
);

    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int CNT_W  = $clog2(SIG_W);
    localparam int EW     = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] MAX_E  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_E = '0;
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                  state, state_next;
    logic                    sign_q;
    logic signed [EW-1:0]    exp_sum_q;
    logic [SIG_W-1:0]        mcand;
    logic [PROD_W-1:0]       acc;
    logic [CNT_W-1:0]        count;

    logic [EXP_W-1:0]        ea, eb;
    logic [FRAC_W-1:0]       fa, fb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                    special, sign_d;
    logic [W-1:0]            special_out;
    logic [3:0]              special_flags;
    logic signed [EW-1:0]    exp_sum_d;

    logic [SIG_W:0]          add_sum;
    logic [PROD_W-1:0]       acc_next;

    logic                    norm;
    logic [PROD_W-2:0]       m;
    logic [FRAC_W-1:0]       frac;
    logic                    guard, round_bit, sticky, inexact_n;
    logic [FRAC_W-1:0]       frac_n;
    logic signed [EW-1:0]    e_n;
    logic [W-1:0]            norm_out;
    logic [3:0]              norm_flags;

    assign ea = in1[W-2 -: EXP_W];
    assign eb = in2[W-2 -: EXP_W];
    assign fa = in1[FRAC_W-1:0];
    assign fb = in2[FRAC_W-1:0];

    // Subnormal inputs (exp==0) are flushed and treated exactly like zero.
    always_comb begin
        a_zero    = (ea == '0);
        b_zero    = (eb == '0);
        a_inf     = (ea == '1) && (fa == '0);
        b_inf     = (eb == '1) && (fb == '0);
        a_nan     = (ea == '1) && (fa != '0);
        b_nan     = (eb == '1) && (fb != '0);
        sign_d    = in1[W-1] ^ in2[W-1];
        special   = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
        exp_sum_d = EW'({2'b00, ea}) + EW'({2'b00, eb}) - BIAS_E;
        special_out   = {sign_d, {(W-1){1'b0}}};
        special_flags = 4'b0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            special_out   = QNAN;
            special_flags = 4'b1000;
        end else if (a_inf || b_inf) begin
            special_out = {sign_d, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end
    end

    // One shift-add step: the multiplier sits in the low half of acc and shifts out as the product grows.
    always_comb begin
        add_sum  = {1'b0, acc[PROD_W-1 -: SIG_W]} + (acc[0] ? {1'b0, mcand} : {(SIG_W+1){1'b0}});
        acc_next = {add_sum, acc[SIG_W-1:1]};
    end

    always_comb begin
        norm      = acc[PROD_W-1];
        m         = norm ? acc[PROD_W-2:0] : {acc[PROD_W-3:0], 1'b0};
        frac      = m[PROD_W-2 -: FRAC_W];
        guard     = m[FRAC_W];
        round_bit = m[FRAC_W-1];
        sticky    = |m[FRAC_W-2:0];
        inexact_n = guard | round_bit | sticky;
`ifdef FP_MUL_RNE_EN
        begin
            logic             round_up;
            logic [FRAC_W:0]  frac_r;
            round_up = guard & (round_bit | sticky | frac[0]);
            frac_r   = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
            frac_n   = frac_r[FRAC_W-1:0];
            e_n      = exp_sum_q + EW'({1'b0, norm}) + EW'({1'b0, frac_r[FRAC_W]});
        end
`else
        frac_n = frac;
        e_n    = exp_sum_q + EW'({1'b0, norm});
`endif
        norm_out   = {sign_q, e_n[EXP_W-1:0], frac_n};
        norm_flags = {3'b000, inexact_n};
        if (e_n >= MAX_E) begin
            norm_out   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            norm_flags = 4'b0101;
        end else if (e_n <= ZERO_E) begin
            norm_out   = {sign_q, {(W-1){1'b0}}};
            norm_flags = 4'b0011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = special ? DONE : MUL;
            end
            MUL:  if (count == CNT_W'(FRAC_W)) state_next = NORM;
            NORM: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q    <= 1'b0;
            exp_sum_q <= '0;
            mcand     <= '0;
            acc       <= '0;
            count     <= '0;
            out       <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_q    <= sign_d;
                    exp_sum_q <= exp_sum_d;
                    mcand     <= {1'b1, fa};
                    acc       <= {{SIG_W{1'b0}}, 1'b1, fb};
                    count     <= '0;
                    if (special) begin
                        out   <= special_out;
                        flags <= special_flags;
                    end
                end
                MUL: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                end
                NORM: begin
                    out   <= norm_out;
                    flags <= norm_flags;
                end
                default: ;
            endcase
        end
    end

endmodule
